// File: rtl/lsu_mem_initiator_if.sv
// ============================================================================
// lsu_req_if / lsu_mem_if : core request channel and single-outstanding bus
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_resp
  );
endinterface

`default_nettype wire

// File: rtl/lsu_mem_initiator.sv
// ============================================================================
// lsu_mem_initiator : RV32I load/store initiator for a single-outstanding bus
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic      clk,
  input  logic      rst,
  lsu_req_if.slave  core,
  lsu_mem_if.master bus
);

  localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             f3_ok;
  logic             misaligned;
  logic             req_bad;
  logic [3:0]       be;
  logic [31:0]      wdata_lanes;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic [31:0]      load_ext;
  logic             issuing;

  // Request legality is judged on the incoming fields so an illegal request
  // never reaches the bus.
  always_comb begin
    f3_ok = 1'b0;
    if (core.req_we) begin
      f3_ok = core.req_funct3 inside {3'b000, 3'b001, 3'b010};
    end else begin
      f3_ok = core.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
    misaligned = ((core.req_funct3[1:0] == 2'b01) && core.req_addr[0]) ||
                 ((core.req_funct3[1:0] == 2'b10) && (core.req_addr[1:0] != 2'b00));
    req_bad = !f3_ok || misaligned;
  end

  always_comb begin
    be          = 4'b1111;
    wdata_lanes = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        be          = 4'b0001 << addr_q[1:0];
        wdata_lanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be          = 4'b0011 << addr_q[1:0];
        wdata_lanes = {2{wdata_q[15:0]}};
      end
      default: begin
        be          = 4'b1111;
        wdata_lanes = wdata_q;
      end
    endcase
  end

  always_comb begin
    lane_b = bus.mem_rdata[7:0];
    case (addr_q[1:0])
      2'd0:    lane_b = bus.mem_rdata[7:0];
      2'd1:    lane_b = bus.mem_rdata[15:8];
      2'd2:    lane_b = bus.mem_rdata[23:16];
      default: lane_b = bus.mem_rdata[31:24];
    endcase
    lane_h = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_ext = {24'h000000, lane_b};
      3'b101:  load_ext = {16'h0000, lane_h};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Response data/error are loaded on the edge into RESP and held afterwards.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (core.req_valid) begin
          we_d     = core.req_we;
          funct3_d = core.req_funct3;
          addr_d   = core.req_addr;
          wdata_d  = core.req_wdata;
          if (req_bad) begin
            state_d = S_RESP;
            rdata_d = 32'h0;
            err_d   = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.mem_resp) begin
          if (we_q) begin
            state_d = S_RESP;
            rdata_d = 32'h0;
            err_d   = 1'b0;
          end else begin
            state_d = S_CAPTURE;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
          rdata_d = 32'h0;
          err_d   = 1'b1;
        end
      end
      S_CAPTURE: begin
        state_d = S_RESP;
        rdata_d = load_ext;
        err_d   = 1'b0;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign issuing = (state_q == S_ISSUE);

  assign core.req_ready  = (state_q == S_IDLE);
  assign core.resp_valid = (state_q == S_RESP);
  assign core.resp_rdata = rdata_q;
  assign core.resp_err   = err_q;

  assign bus.mem_read  = issuing && !we_q;
  assign bus.mem_write = issuing && we_q;
  assign bus.mem_addr  = issuing ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.mem_be    = issuing ? be : 4'b0000;
  assign bus.mem_wdata = (issuing && we_q) ? wdata_lanes : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_initiator.sv
// ============================================================================
// tb_lsu_mem_initiator : directed + random checks against a byte-level model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_mem_initiator;

  localparam int unsigned TIMEOUT = 16;

  logic clk;
  logic rst;

  lsu_req_if core_if ();
  lsu_mem_if mem_if ();

  lsu_mem_initiator #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk  (clk),
    .rst  (rst),
    .core (core_if),
    .bus  (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: byte-addressed memory, unwritten bytes read as zero.
  bit [7:0]  ref_mem [bit [31:0]];
  // Responder's own word storage.
  bit [31:0] bus_mem [bit [31:0]];

  int unsigned rsp_delay = 2;   // 0 = never respond
  bit          late_pulse = 1'b0;
  int unsigned n_reads = 0, n_writes = 0, idle_viol = 0, pend = 0;
  bit          p_we;
  bit [31:0]   p_addr;
  bit [31:0]   last_addr, last_wdata;
  bit [3:0]    last_be;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit [7:0] ref_byte(input bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic bit [31:0] bus_word(input bit [31:0] wa);
    return bus_mem.exists(wa) ? bus_mem[wa] : 32'h0;
  endfunction

  function automatic int unsigned acc_size(input bit [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit req_illegal(input bit we, input bit [2:0] f3, input bit [31:0] a);
    bit legal;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 1'b1;
    return (a % acc_size(f3)) != 0;
  endfunction

  function automatic bit [31:0] exp_load(input bit [2:0] f3, input bit [31:0] a);
    int unsigned sz;
    longint      v;
    sz = acc_size(f3);
    v  = 0;
    for (int i = 0; i < int'(sz); i++) v = v + (longint'(ref_byte(a + i)) << (8 * i));
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  function automatic bit [3:0] exp_be(input bit [2:0] f3, input bit [31:0] a);
    bit [3:0] m = 4'b0000;
    for (int i = 0; i < int'(acc_size(f3)); i++) m[(a % 4) + i] = 1'b1;
    return m;
  endfunction

  function automatic bit [31:0] exp_wdata(input bit [2:0] f3, input bit [31:0] wd);
    bit [31:0] r;
    int unsigned sz;
    sz = acc_size(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic void ref_store(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd);
    for (int i = 0; i < int'(acc_size(f3)); i++) ref_mem[a + i] = wd[8*i +: 8];
  endfunction

  function automatic void preload(input bit [31:0] a, input bit [31:0] w);
    for (int i = 0; i < 4; i++) ref_mem[a + i] = w[8*i +: 8];
    bus_mem[a >> 2] = w;
  endfunction

  // Bus responder: answers rsp_delay negedges after seeing the request pulse.
  initial begin
    mem_if.mem_resp  = 1'b0;
    mem_if.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_if.mem_resp = 1'b0;
      if (late_pulse) begin
        mem_if.mem_resp = 1'b1;
        late_pulse      = 1'b0;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_if.mem_resp = 1'b1;
          if (!p_we) mem_if.mem_rdata = bus_word(p_addr >> 2);
        end
      end
      if (mem_if.mem_read || mem_if.mem_write) begin
        if (mem_if.mem_read)  n_reads++;
        if (mem_if.mem_write) n_writes++;
        last_addr  = mem_if.mem_addr;
        last_be    = mem_if.mem_be;
        last_wdata = mem_if.mem_wdata;
        p_we       = mem_if.mem_write;
        p_addr     = mem_if.mem_addr;
        pend       = rsp_delay;
        if (mem_if.mem_write) begin
          bit [31:0] w;
          w = bus_word(mem_if.mem_addr >> 2);
          for (int i = 0; i < 4; i++) if (mem_if.mem_be[i]) w[8*i +: 8] = mem_if.mem_wdata[8*i +: 8];
          bus_mem[mem_if.mem_addr >> 2] = w;
        end
      end else if (mem_if.mem_addr != 0 || mem_if.mem_be != 0 || mem_if.mem_wdata != 0) begin
        idle_viol++;
      end
    end
  end

  task automatic run_req(input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                         output int lat, output bit [31:0] rd, output bit er);
    int guard = 0;
    @(negedge clk);
    while (!core_if.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_before_req", 32'(core_if.req_ready), 32'd1);
    core_if.req_valid  = 1'b1;
    core_if.req_we     = we;
    core_if.req_funct3 = f3;
    core_if.req_addr   = a;
    core_if.req_wdata  = wd;
    @(negedge clk);
    core_if.req_valid = 1'b0;
    lat = 1;
    while (!core_if.resp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    rd = core_if.resp_rdata;
    er = core_if.resp_err;
  endtask

  task automatic exec(input string tag, input bit we, input bit [2:0] f3, input bit [31:0] a,
                      input bit [31:0] wd, output bit [31:0] rd);
    int unsigned nr0, nw0;
    int          lat, exp_lat;
    bit          er, bad, tmo;
    bit [31:0]   exp_rd;
    bad    = req_illegal(we, f3, a);
    tmo    = !bad && (rsp_delay == 0 || rsp_delay > TIMEOUT);
    exp_rd = (bad || we || tmo) ? 32'h0 : exp_load(f3, a);
    if (bad)      exp_lat = 1;
    else if (tmo) exp_lat = 2 + int'(TIMEOUT);
    else if (we)  exp_lat = 2 + int'(rsp_delay);
    else          exp_lat = 3 + int'(rsp_delay);
    nr0 = n_reads;
    nw0 = n_writes;
    run_req(we, f3, a, wd, lat, rd, er);
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".err"}, 32'(er), 32'(bad || tmo));
    check({tag, ".rdata"}, rd, exp_rd);
    check({tag, ".reads"}, n_reads - nr0, 32'(!bad && !we));
    check({tag, ".writes"}, n_writes - nw0, 32'(!bad && we));
    if (!bad) begin
      check({tag, ".addr"}, last_addr, {a[31:2], 2'b00});
      check({tag, ".be"}, 32'(last_be), 32'(exp_be(f3, a)));
      if (we) begin
        check({tag, ".wdata"}, last_wdata, exp_wdata(f3, wd));
        ref_store(f3, a, wd);
      end
    end
  endtask

  initial begin
    bit [31:0]   rd;
    int unsigned cnt_a, cnt_b;
    rst                = 1'b1;
    core_if.req_valid  = 1'b0;
    core_if.req_we     = 1'b0;
    core_if.req_funct3 = 3'b000;
    core_if.req_addr   = 32'h0;
    core_if.req_wdata  = 32'h0;
    repeat (3) @(negedge clk);
    check("rst.req_ready", 32'(core_if.req_ready), 32'd1);
    check("rst.resp_valid", 32'(core_if.resp_valid), 32'd0);
    check("rst.resp_rdata", core_if.resp_rdata, 32'h0);
    check("rst.resp_err", 32'(core_if.resp_err), 32'd0);
    check("rst.mem_rw", {30'b0, mem_if.mem_read, mem_if.mem_write}, 32'h0);
    check("rst.mem_addr_be", mem_if.mem_addr | 32'(mem_if.mem_be), 32'h0);
    rst = 1'b0;

    preload(32'h100, 32'hDEADBEEF);
    rsp_delay = 2;
    exec("lw", 1'b0, 3'b010, 32'h100, 32'h0, rd);
    check("lw.const", rd, 32'hDEADBEEF);
    exec("lb", 1'b0, 3'b000, 32'h103, 32'h0, rd);
    check("lb.const", rd, 32'hFFFFFFDE);
    exec("lbu", 1'b0, 3'b100, 32'h103, 32'h0, rd);
    check("lbu.const", rd, 32'h000000DE);
    exec("lh", 1'b0, 3'b001, 32'h102, 32'h0, rd);
    check("lh.const", rd, 32'hFFFFDEAD);
    exec("lhu", 1'b0, 3'b101, 32'h100, 32'h0, rd);
    check("lhu.const", rd, 32'h0000BEEF);

    exec("sb", 1'b1, 3'b000, 32'h201, 32'h000000A5, rd);
    check("sb.be_const", 32'(last_be), 32'h2);
    check("sb.wdata_const", last_wdata, 32'hA5A5A5A5);
    exec("lw_after_sb", 1'b0, 3'b010, 32'h200, 32'h0, rd);
    check("lw_after_sb.const", rd, 32'h0000A500);
    exec("sh", 1'b1, 3'b001, 32'h202, 32'h00001234, rd);
    check("sh.be_const", 32'(last_be), 32'hC);
    check("sh.wdata_const", last_wdata, 32'h12341234);

    exec("lw_misaligned", 1'b0, 3'b010, 32'h102, 32'h0, rd);
    exec("load_f3_011", 1'b0, 3'b011, 32'h100, 32'h0, rd);

    rsp_delay = 0;
    exec("timeout", 1'b0, 3'b010, 32'h100, 32'h0, rd);
    late_pulse = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    repeat (4) begin
      @(negedge clk);
      if (core_if.resp_valid) cnt_a++;
      if (!core_if.req_ready) cnt_b++;
    end
    check("late_resp.no_resp_valid", cnt_a, 32'd0);
    check("late_resp.stays_idle", cnt_b, 32'd0);
    rsp_delay = 2;
    exec("after_timeout", 1'b0, 3'b010, 32'h100, 32'h0, rd);

    // Response arriving on the final WAIT cycle must beat the timeout.
    rsp_delay = TIMEOUT;
    exec("resp_at_threshold", 1'b0, 3'b001, 32'h102, 32'h0, rd);

    rsp_delay = 0;
    @(negedge clk);
    core_if.req_valid  = 1'b1;
    core_if.req_we     = 1'b0;
    core_if.req_funct3 = 3'b010;
    core_if.req_addr   = 32'h100;
    @(negedge clk);
    core_if.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst.req_ready", 32'(core_if.req_ready), 32'd1);
    check("midrst.resp", {core_if.resp_rdata[30:0], core_if.resp_valid} | 32'(core_if.resp_err), 32'h0);
    check("midrst.mem", {30'b0, mem_if.mem_read, mem_if.mem_write} | mem_if.mem_addr |
                        mem_if.mem_wdata | 32'(mem_if.mem_be), 32'h0);
    rst   = 1'b0;
    cnt_a = 0;
    repeat (20) begin
      @(negedge clk);
      if (core_if.resp_valid) cnt_a++;
    end
    check("midrst.no_stale_resp", cnt_a, 32'd0);
    rsp_delay = 2;
    exec("after_midrst", 1'b0, 3'b010, 32'h100, 32'h0, rd);

    for (int i = 0; i < 40; i++) begin
      rsp_delay = $urandom_range(1, 4);
      exec($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           32'h300 + 32'($urandom_range(0, 63)), $urandom, rd);
    end

    check("bus_zero_outside_issue", idle_viol, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
